hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the simple RV32I pipeline (IF, ID, EX, MEM, WB). It snoops the instruction in ID and keeps its own shadow pipeline of decoded register-use information for EX, MEM and WB. From that it generates the load-use stall, the control-redirect flush sequence and the EX-stage operand forwarding selects. It sits beside the decode controller and drives the pipeline-register enables, flush inputs and the forwarding muxes.

---
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use stall,
// taken-redirect flush sequence and EX operand forwarding from a shadow register-use pipeline.
//
// state | meaning
// RUN   | normal issue; detect redirects and load-use hazards
// FLUSH | squashing wrong-path fetches after a taken redirect
module hazard_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             ex_br_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FW = $clog2(FLUSH_DEPTH + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic [4:0] rd;
        logic       reg_wr;
        logic       is_load;
        logic       is_ctrl;
    } slot_t;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state;
    logic [FW-1:0] fcnt;
    slot_t         id_dec, ex_s, mem_s, wb_s;
    logic          redirect, load_use, rs_hit;

    always_comb begin
        id_dec       = '0;
        id_dec.valid = id_valid;
        id_dec.rs1   = id_inst[19:15];
        id_dec.rs2   = id_inst[24:20];
        id_dec.rd    = id_inst[11:7];
        case (id_inst[6:0])
            OP_R:     begin id_dec.uses_rs1 = 1'b1; id_dec.uses_rs2 = 1'b1; id_dec.reg_wr = 1'b1; end
            OP_I:     begin id_dec.uses_rs1 = 1'b1; id_dec.reg_wr = 1'b1; end
            OP_LOAD:  begin id_dec.uses_rs1 = 1'b1; id_dec.reg_wr = 1'b1; id_dec.is_load = 1'b1; end
            OP_STORE: begin id_dec.uses_rs1 = 1'b1; id_dec.uses_rs2 = 1'b1; end
            OP_BR:    begin id_dec.uses_rs1 = 1'b1; id_dec.uses_rs2 = 1'b1; id_dec.is_ctrl = 1'b1; end
            OP_JAL:   begin id_dec.reg_wr = 1'b1; id_dec.is_ctrl = 1'b1; end
            OP_JALR:  begin id_dec.uses_rs1 = 1'b1; id_dec.reg_wr = 1'b1; id_dec.is_ctrl = 1'b1; end
            OP_LUI,
            OP_AUIPC: id_dec.reg_wr = 1'b1;
            default:  ;
        endcase
        // x0 is never a producer, so it can neither forward nor stall
        if (id_dec.rd == 5'd0)
            id_dec.reg_wr = 1'b0;
    end

    always_comb begin
        redirect = (state == RUN) && ex_s.valid && ex_s.is_ctrl && ex_br_taken;
        rs_hit   = (id_dec.uses_rs1 && (id_dec.rs1 == ex_s.rd)) ||
                   (id_dec.uses_rs2 && (id_dec.rs2 == ex_s.rd));
        load_use = (state == RUN) && !redirect && ex_s.valid && ex_s.is_load &&
                   (ex_s.rd != 5'd0) && id_valid && rs_hit;
    end

    assign stall_pc    = load_use;
    assign stall_ifid  = load_use;
    assign flush_ifid  = redirect || (state == FLUSH);
    assign bubble_idex = flush_ifid || load_use;
    assign ex_valid    = ex_s.valid;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic uses,
                                           input slot_t ex, input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex.valid && uses) begin
            if (mem.valid && mem.reg_wr && (mem.rd != 5'd0) && (mem.rd == rs))
                sel = 2'b01;
            else if (wb.valid && wb.reg_wr && (wb.rd != 5'd0) && (wb.rd == rs))
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_s.rs1, ex_s.uses_rs1, ex_s, mem_s, wb_s);
        fwd_b = fwd_sel(ex_s.rs2, ex_s.uses_rs2, ex_s, mem_s, wb_s);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            fcnt        <= '0;
            ex_s        <= '0;
            mem_s       <= '0;
            wb_s        <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            ex_s  <= (bubble_idex || !id_valid) ? slot_t'('0) : id_dec;

            if (load_use && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
            if (redirect && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;

            case (state)
                RUN: begin
                    if (redirect && (FLUSH_DEPTH > 1)) begin
                        state <= FLUSH;
                        fcnt  <= FW'(FLUSH_DEPTH - 1);
                    end
                end
                FLUSH: begin
                    if (fcnt <= FW'(1)) begin
                        state <= RUN;
                        fcnt  <= '0;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{id_inst[31:25], id_inst[14:12], wb_s.rs1, wb_s.rs2, wb_s.uses_rs1,
                           wb_s.uses_rs2, wb_s.is_load, wb_s.is_ctrl, mem_s.rs1, mem_s.rs2,
                           mem_s.uses_rs1, mem_s.uses_rs2, mem_s.is_load, mem_s.is_ctrl};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations queued with the stimulus
// and popped when the outputs settle; small counter width makes saturation reachable.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [31:0]   id_inst = 32'h13;
    logic          ex_br_taken = 1'b0;
    logic          stall_pc, stall_ifid, flush_ifid, bubble_idex, ex_valid;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count, flush_count;

    hazard_ctrl #(.FLUSH_DEPTH(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .ex_br_taken(ex_br_taken), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .flush_ifid(flush_ifid), .bubble_idex(bubble_idex), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_valid(ex_valid), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       chk;
        logic     stl;
        logic     fl;
        logic     bub;
        logic [1:0] fa;
        logic [1:0] fb;
        logic     exv;
        int       sc;
        int       fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic stl, input logic fl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic exv, input int sc, input int fc);
        exp_t e;
        e.chk = 1'b1; e.stl = stl; e.fl = fl; e.bub = stl | fl;
        e.fa = fa; e.fb = fb; e.exv = exv; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] addi_op(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw_op(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] beq_op(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction

    task automatic step(input logic rst, input logic v, input logic [31:0] inst,
                        input logic br, input exp_t e);
        exp_t got;
        @(posedge clk);
        #1;
        rst_n = rst; id_valid = v; id_inst = inst; ex_br_taken = br;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            if (got.chk) begin
                chk("stall_pc",    {31'd0, stall_pc},    {31'd0, got.stl});
                chk("stall_ifid",  {31'd0, stall_ifid},  {31'd0, got.stl});
                chk("flush_ifid",  {31'd0, flush_ifid},  {31'd0, got.fl});
                chk("bubble_idex", {31'd0, bubble_idex}, {31'd0, got.bub});
                chk("fwd_a",       {30'd0, fwd_a},       {30'd0, got.fa});
                chk("fwd_b",       {30'd0, fwd_b},       {30'd0, got.fb});
                chk("ex_valid",    {31'd0, ex_valid},    {31'd0, got.exv});
                chk("stall_count", 32'(stall_count),     32'(got.sc));
                chk("flush_count", 32'(flush_count),     32'(got.fc));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t skip;
        exp_t z;
        logic [31:0] nop;
        skip = mk(0, 0, 0, 0, 0, 0, 0);
        skip.chk = 1'b0;
        z = mk(0, 0, 0, 0, 0, 0, 0);
        nop = addi_op(5'd0, 5'd0, 12'd0);

        // reset held with live-looking ID traffic
        step(0, 1, $urandom(), 0, skip);
        step(0, 1, $urandom(), 0, z);
        step(0, 1, $urandom(), 0, z);

        // lw x5 then add x6,x5,x2: one stall cycle, then WB forward
        step(1, 1, lw_op(5'd5, 5'd1), 0, z);
        step(1, 1, r_op(7'd0, 5'd6, 5'd5, 5'd2), 0, mk(1, 0, 2'b00, 2'b00, 1, 0, 0));
        step(1, 1, r_op(7'd0, 5'd6, 5'd5, 5'd2), 0, mk(0, 0, 2'b00, 2'b00, 0, 1, 0));
        step(1, 1, r_op(7'd0, 5'd3, 5'd1, 5'd2), 0, mk(0, 0, 2'b10, 2'b00, 1, 1, 0));
        // add x3 then sub x4,x3,x3: MEM forward on both operands
        step(1, 1, r_op(7'b0100000, 5'd4, 5'd3, 5'd3), 0, mk(0, 0, 2'b00, 2'b00, 1, 1, 0));
        step(1, 1, addi_op(5'd0, 5'd0, 12'd5), 0, mk(0, 0, 2'b01, 2'b01, 1, 1, 0));
        // x0 writers never forward or stall
        step(1, 1, r_op(7'd0, 5'd7, 5'd0, 5'd0), 0, mk(0, 0, 2'b00, 2'b00, 1, 1, 0));
        step(1, 1, lw_op(5'd0, 5'd1), 0, mk(0, 0, 2'b00, 2'b00, 1, 1, 0));
        step(1, 1, r_op(7'd0, 5'd8, 5'd0, 5'd0), 0, mk(0, 0, 2'b00, 2'b00, 1, 1, 0));
        step(1, 1, beq_op(5'd1, 5'd2), 0, mk(0, 0, 2'b00, 2'b00, 1, 1, 0));

        // taken beq: two flush cycles, second taken pulse and load-use pattern ignored
        step(1, 1, lw_op(5'd9, 5'd1), 1, mk(0, 1, 2'b00, 2'b00, 1, 1, 0));
        step(1, 1, r_op(7'd0, 5'd10, 5'd9, 5'd9), 1, mk(0, 1, 2'b00, 2'b00, 0, 1, 1));
        step(1, 1, nop, 1, mk(0, 0, 2'b00, 2'b00, 0, 1, 1));
        step(1, 1, beq_op(5'd1, 5'd2), 0, mk(0, 0, 2'b00, 2'b00, 1, 1, 1));

        // second redirect, then reset lands in the first flush cycle
        step(1, 1, nop, 1, mk(0, 1, 2'b00, 2'b00, 1, 1, 1));
        step(0, 1, nop, 0, mk(0, 1, 2'b00, 2'b00, 0, 1, 2));
        step(1, 1, nop, 0, z);

        // self-dependent loads stall every other cycle until the counter saturates
        step(1, 1, lw_op(5'd5, 5'd5), 0, mk(0, 0, 2'b00, 2'b00, 1, 0, 0));
        for (int i = 0; i < 18; i++) begin
            step(1, 1, lw_op(5'd5, 5'd5), 0,
                 mk(1, 0, (i == 0) ? 2'b00 : 2'b10, 2'b00, 1, (i < CMAX) ? i : CMAX, 0));
            step(1, 1, lw_op(5'd5, 5'd5), 0,
                 mk(0, 0, 2'b00, 2'b00, 0, (i + 1 < CMAX) ? i + 1 : CMAX, 0));
        end
        step(1, 1, nop, 0, mk(0, 0, 2'b10, 2'b00, 1, CMAX, 0));

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
